// File: rtl/crc_stream_sched_if.sv
// Stream request and result handshake bundle for crc_stream_sched.
// The master side feeds beats and consumes results. The slave side is the scheduler.
interface crc_stream_sched_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_BYTES = 8,
    parameter int CRC_WIDTH  = 32
);
    localparam int CHW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]              in_valid;
    logic [NUM_CH-1:0]              in_last;
    logic [NUM_CH*8*DATA_BYTES-1:0] in_data;
    logic [NUM_CH-1:0]              in_ready;
    logic                           res_valid;
    logic                           res_ready;
    logic [CHW-1:0]                 res_ch;
    logic [CRC_WIDTH-1:0]           res_crc;

    modport master (
        output in_valid, in_last, in_data, res_ready,
        input  in_ready, res_valid, res_ch, res_crc
    );

    modport slave (
        input  in_valid, in_last, in_data, res_ready,
        output in_ready, res_valid, res_ch, res_crc
    );
endinterface

// File: rtl/crc_stream_sched.sv
// Round-robin frame scheduler sharing one registered CRC engine among NUM_CH streams.
// It carries the running remainder between beats and applies reflection and xorout to the result.
module crc_stream_sched #(
    parameter int NUM_CH     = 4,
    parameter int DATA_BYTES = 8,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    crc_stream_sched_if.slave           bus,
    input  logic [NUM_CH*CRC_WIDTH-1:0] cfg_poly,
    input  logic [NUM_CH*CRC_WIDTH-1:0] cfg_init,
    input  logic [NUM_CH*CRC_WIDTH-1:0] cfg_xorout,
    input  logic [NUM_CH-1:0]           cfg_refin,
    input  logic [NUM_CH-1:0]           cfg_refout,
    output logic                        busy,
    output logic [8*DATA_BYTES-1:0]     eng_data,
    output logic [CRC_WIDTH-1:0]        eng_crc_in,
    output logic [CRC_WIDTH-1:0]        eng_poly,
    output logic                        eng_enable,
    output logic                        eng_reflect_in,
    input  logic [CRC_WIDTH-1:0]        eng_crc_out
);
    localparam int CHW = $clog2(NUM_CH);
    localparam int DW  = 8 * DATA_BYTES;
    localparam int CW  = CRC_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINAL, S_RESULT} state_t;

    state_t         state, state_nx;
    logic [CHW-1:0] rr_ptr, gnt, pick, cand;
    logic           found;
    int             arb_idx;
    logic [CW-1:0]  acc, poly_q, xorout_q, res_crc_q;
    logic           refin_q, refout_q, last_q, res_valid_q;
    logic [CHW-1:0] res_ch_q;

    function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < CW; i++) r[i] = v[CW-1-i];
        return r;
    endfunction

    // First requester strictly after the last served channel, wrapping
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        arb_idx = 0;
        cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
            cand = CHW'(arb_idx);
            if (!found && bus.in_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (found) state_nx = S_ISSUE;
            S_ISSUE:  if (bus.in_valid[gnt]) state_nx = S_WAIT;
            S_WAIT:   state_nx = last_q ? S_FINAL : S_ISSUE;
            S_FINAL:  state_nx = S_RESULT;
            S_RESULT: if (bus.res_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = '0;
        eng_enable   = 1'b0;
        if (state == S_ISSUE) begin
            bus.in_ready[gnt] = 1'b1;
            eng_enable        = bus.in_valid[gnt];
        end
    end

    assign busy           = (state != S_IDLE);
    assign eng_data       = bus.in_data[int'(gnt)*DW +: DW];
    assign eng_crc_in     = acc;
    assign eng_poly       = poly_q;
    assign eng_reflect_in = refin_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_ch     = res_ch_q;
    assign bus.res_crc    = res_crc_q;

    // Config is captured once at grant so source-side changes mid-frame are harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= CHW'(NUM_CH - 1);
            gnt         <= '0;
            acc         <= '0;
            poly_q      <= '0;
            xorout_q    <= '0;
            refin_q     <= 1'b0;
            refout_q    <= 1'b0;
            last_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_crc_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (found) begin
                    gnt      <= pick;
                    poly_q   <= cfg_poly[int'(pick)*CW +: CW];
                    xorout_q <= cfg_xorout[int'(pick)*CW +: CW];
                    refin_q  <= cfg_refin[pick];
                    refout_q <= cfg_refout[pick];
                    acc      <= cfg_init[int'(pick)*CW +: CW];
                end
                S_ISSUE: if (bus.in_valid[gnt]) last_q <= bus.in_last[gnt];
                S_WAIT:  acc <= eng_crc_out;
                S_FINAL: begin
                    res_crc_q   <= (refout_q ? bitrev(acc) : acc) ^ xorout_q;
                    res_ch_q    <= gnt;
                    res_valid_q <= 1'b1;
                end
                S_RESULT: if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                    rr_ptr      <= gnt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_stream_sched.sv
// Randomized and directed bench for crc_stream_sched with a byte-wise engine stand-in
// and a bit-serial CRC reference computed over whole frames.
module tb_crc_stream_sched;
    localparam int NCH = 4, DB = 1, CW = 32, CHW = $clog2(NCH), MAXB = 16;

    typedef struct packed {
        logic [7:0]            len;
        logic [MAXB-1:0][7:0]  b;
        logic [CW-1:0]         poly, init, xo;
        logic                  ri, ro;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc_stream_sched_if #(.NUM_CH(NCH), .DATA_BYTES(DB), .CRC_WIDTH(CW)) bus ();

    logic [NCH*CW-1:0] cfg_poly = '0, cfg_init = '0, cfg_xorout = '0;
    logic [NCH-1:0]    cfg_refin = '0, cfg_refout = '0;
    logic              busy, eng_enable, eng_reflect_in, eng_n_rst;
    logic [8*DB-1:0]   eng_data;
    logic [CW-1:0]     eng_crc_in, eng_poly, eng_crc_out;

    crc_stream_sched #(.NUM_CH(NCH), .DATA_BYTES(DB), .CRC_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_xorout(cfg_xorout),
        .cfg_refin(cfg_refin), .cfg_refout(cfg_refout), .busy(busy),
        .eng_data(eng_data), .eng_crc_in(eng_crc_in), .eng_poly(eng_poly),
        .eng_enable(eng_enable), .eng_reflect_in(eng_reflect_in), .eng_crc_out(eng_crc_out)
    );

    int checks = 0, errors = 0;
    frame_t cur [NCH];
    logic   active [NCH];
    int     pos [NCH], stall [NCH], stall_pos [NCH], stall_n [NCH];
    logic [CW+7:0] expq[$];
    int     order_q[$];
    logic   gap_en = 1'b0;
    int     sink_mode = 1;
    int     last_ch = -1;
    logic [CW-1:0] last_crc = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [CW-1:0] rev_cw(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < CW; i++) r[i] = v[CW-1-i];
        return r;
    endfunction

    // Engine stand-in: byte-wise MSB-first update, registered, no output reflect or xor
    function automatic logic [CW-1:0] eng_step(input logic [8*DB-1:0] d, input logic [CW-1:0] c_in,
                                               input logic [CW-1:0] p, input logic ri);
        logic [CW-1:0] c;
        logic [7:0]    b;
        c = c_in;
        for (int j = DB - 1; j >= 0; j--) begin
            b = d[j*8 +: 8];
            if (ri) b = rev8(b);
            c = c ^ {b, {(CW-8){1'b0}}};
            for (int k = 0; k < 8; k++) c = c[CW-1] ? ((c << 1) ^ p) : (c << 1);
        end
        return c;
    endfunction

    assign eng_n_rst = ~rst;
    always @(posedge clk or negedge eng_n_rst)
        if (!eng_n_rst)     eng_crc_out <= '0;
        else if (eng_enable) eng_crc_out <= eng_step(eng_data, eng_crc_in, eng_poly, eng_reflect_in);

    // Reference: textbook bit-at-a-time CRC over the whole message
    function automatic logic [CW-1:0] crc_ref(input frame_t f);
        logic [CW-1:0] c;
        logic bt, fb;
        c = f.init;
        for (int i = 0; i < int'(f.len); i++)
            for (int k = 0; k < 8; k++) begin
                bt = f.ri ? f.b[i][k] : f.b[i][7-k];
                fb = c[CW-1] ^ bt;
                c  = c << 1;
                if (fb) c = c ^ f.poly;
            end
        if (f.ro) c = rev_cw(c);
        return c ^ f.xo;
    endfunction

    function automatic frame_t rand_frame(input int len);
        frame_t f;
        f = '0;
        f.len  = 8'(len);
        for (int i = 0; i < MAXB; i++) f.b[i] = 8'($urandom_range(0, 255));
        f.poly = $urandom() | 32'h1;
        f.init = $urandom();
        f.xo   = $urandom();
        f.ri   = 1'($urandom_range(0, 1));
        f.ro   = 1'($urandom_range(0, 1));
        return f;
    endfunction

    function automatic frame_t check_frame(input logic refl, input logic [CW-1:0] xo);
        frame_t f;
        f = '0;
        f.len  = 8'd9;
        for (int i = 0; i < 9; i++) f.b[i] = 8'h31 + 8'(i);
        f.poly = 32'h04C11DB7;
        f.init = 32'hFFFFFFFF;
        f.xo   = xo;
        f.ri   = refl;
        f.ro   = refl;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int ch, input frame_t f);
        cur[ch]    = f;
        pos[ch]    = 0;
        stall[ch]  = 0;
        active[ch] = 1'b1;
        expq.push_back({8'(ch), crc_ref(f)});
    endtask

    function automatic logic any_active();
        logic a;
        a = 1'b0;
        for (int i = 0; i < NCH; i++) a = a | active[i];
        return a;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((any_active() || expq.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 1);
    endtask

    // Source: holds valid until accepted, optional gaps between beats, scrambles cfg after grant
    initial begin : drv
        logic [NCH-1:0] fire;
        bus.in_valid = '0;
        bus.in_last  = '0;
        bus.in_data  = '0;
        forever begin
            @(negedge clk);
            fire = bus.in_valid & bus.in_ready;
            @(posedge clk);
            #1;
            for (int ch = 0; ch < NCH; ch++) begin
                if (fire[ch] && active[ch]) begin
                    bus.in_valid[ch] = 1'b0;
                    if (pos[ch] == 0) begin
                        cfg_poly[ch*CW +: CW]   = $urandom();
                        cfg_init[ch*CW +: CW]   = $urandom();
                        cfg_xorout[ch*CW +: CW] = $urandom();
                        cfg_refin[ch]           = ~cfg_refin[ch];
                        cfg_refout[ch]          = ~cfg_refout[ch];
                    end
                    pos[ch]++;
                    if (pos[ch] >= int'(cur[ch].len)) active[ch] = 1'b0;
                    else if (pos[ch] == stall_pos[ch]) stall[ch] = stall_n[ch];
                    else if (gap_en && $urandom_range(0, 3) == 0) stall[ch] = $urandom_range(1, 3);
                end
                if (!active[ch]) bus.in_valid[ch] = 1'b0;
                else if (!bus.in_valid[ch]) begin
                    if (stall[ch] > 0) stall[ch]--;
                    else begin
                        if (pos[ch] == 0) begin
                            cfg_poly[ch*CW +: CW]   = cur[ch].poly;
                            cfg_init[ch*CW +: CW]   = cur[ch].init;
                            cfg_xorout[ch*CW +: CW] = cur[ch].xo;
                            cfg_refin[ch]           = cur[ch].ri;
                            cfg_refout[ch]          = cur[ch].ro;
                        end
                        bus.in_valid[ch]           = 1'b1;
                        bus.in_data[ch*8*DB +: 8*DB] = cur[ch].b[pos[ch]];
                        bus.in_last[ch]            = (pos[ch] == int'(cur[ch].len) - 1);
                    end
                end
            end
        end
    end

    // Sink and per-channel in-order scoreboard
    initial begin : snk
        int idx;
        bus.res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.res_valid && bus.res_ready && !rst) begin
                idx = -1;
                for (int i = 0; i < expq.size(); i++)
                    if (idx < 0 && expq[i][CW +: 8] == 8'(bus.res_ch)) idx = i;
                chk("res_expected", 64'(idx >= 0), 1);
                if (idx >= 0) begin
                    chk("res_crc", bus.res_crc, expq[idx][CW-1:0]);
                    expq.delete(idx);
                end
                order_q.push_back(int'(bus.res_ch));
                last_ch  = int'(bus.res_ch);
                last_crc = bus.res_crc;
            end
            @(posedge clk);
            #1;
            case (sink_mode)
                0:       bus.res_ready = 1'($urandom_range(0, 1));
                1:       bus.res_ready = 1'b1;
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_ch"}, bus.res_ch, 0);
        chk({tag, "_res_crc"}, bus.res_crc, 0);
        chk({tag, "_eng_enable"}, eng_enable, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin : main
        frame_t f;
        int n, idle_cyc;
        for (int i = 0; i < NCH; i++) begin
            active[i] = 1'b0; pos[i] = 0; stall[i] = 0; stall_pos[i] = -1; stall_n[i] = 0;
        end
        repeat (3) tick();
        chk_reset_outs("reset");
        rst = 1'b0;
        tick();

        // CRC-32 check value on ch1
        load(1, check_frame(1'b1, 32'hFFFFFFFF));
        wait_idle(200);
        chk("t1_ch", 64'(last_ch), 1);
        chk("t1_crc", last_crc, 32'hCBF43926);

        // CRC-32/MPEG-2 on ch0
        load(0, check_frame(1'b0, 32'h0));
        wait_idle(200);
        chk("t2_ch", 64'(last_ch), 0);
        chk("t2_crc", last_crc, 32'h0376E6E7);

        // Round-robin order from reset
        rst = 1'b1; tick(); rst = 1'b0; tick();
        order_q.delete();
        load(0, rand_frame($urandom_range(1, 4)));
        load(2, rand_frame($urandom_range(1, 4)));
        wait_idle(300);
        chk("t3a_n", 64'(order_q.size()), 2);
        if (order_q.size() >= 2) begin
            chk("t3a_first", 64'(order_q[0]), 0);
            chk("t3a_second", 64'(order_q[1]), 2);
        end
        order_q.delete();
        load(0, rand_frame($urandom_range(1, 4)));
        load(2, rand_frame($urandom_range(1, 4)));
        load(3, rand_frame($urandom_range(1, 4)));
        wait_idle(400);
        chk("t3b_n", 64'(order_q.size()), 3);
        if (order_q.size() >= 3) begin
            chk("t3b_first", 64'(order_q[0]), 3);
            chk("t3b_second", 64'(order_q[1]), 0);
            chk("t3b_third", 64'(order_q[2]), 2);
        end

        // Single-beat latency and result back-pressure
        sink_mode = 2;
        tick();
        f = rand_frame(1);
        load(1, f);
        tick();
        chk("t4_grant_cyc_rdy", bus.in_ready, 0);
        tick();
        chk("t4_issue_rdy", bus.in_ready, 4'b0010);
        tick();
        chk("t4_wait_rdy", bus.in_ready, 0);
        chk("t4_wait_rv", bus.res_valid, 0);
        tick();
        chk("t4_final_rv", bus.res_valid, 0);
        tick();
        chk("t4_result_rv", bus.res_valid, 1);
        load(2, rand_frame($urandom_range(1, 3)));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_rv", bus.res_valid, 1);
            chk("t4_hold_ch", bus.res_ch, 1);
            chk("t4_hold_crc", bus.res_crc, crc_ref(f));
            chk("t4_hold_rdy", bus.in_ready, 0);
        end
        sink_mode = 1;
        wait_idle(200);

        // Granted channel stalls mid-frame while another channel requests
        order_q.delete();
        stall_pos[1] = 2;
        stall_n[1]   = 4;
        load(1, rand_frame(5));
        n = 0;
        while (!bus.in_ready[1] && n < 20) begin tick(); n++; end
        chk("t5_granted", bus.in_ready[1], 1);
        load(2, rand_frame($urandom_range(1, 4)));
        idle_cyc = 0;
        n = 0;
        while (active[1] && n < 60) begin
            if (!bus.in_valid[1] && bus.in_ready != 0) begin
                idle_cyc++;
                chk("t5_stall_rdy", bus.in_ready, 4'b0010);
            end
            tick();
            n++;
        end
        chk("t5_idle_cycles", 64'(idle_cyc), 3);
        wait_idle(300);
        stall_pos[1] = -1;
        chk("t5_n", 64'(order_q.size()), 2);
        if (order_q.size() >= 2) begin
            chk("t5_first", 64'(order_q[0]), 1);
            chk("t5_second", 64'(order_q[1]), 2);
        end

        // Reset during the WAIT of beat 2, then a clean frame
        load(0, rand_frame(4));
        n = 0;
        while (pos[0] != 2 && n < 40) begin tick(); n++; end
        chk("t6_reached_wait", 64'(pos[0]), 2);
        chk("t6_wait_rdy", bus.in_ready, 0);
        rst = 1'b1;
        active[0] = 1'b0;
        expq.delete();
        tick();
        chk_reset_outs("t6_rst");
        rst = 1'b0;
        tick();
        f = rand_frame(6);
        load(2, f);
        wait_idle(300);
        chk("t6_after_ch", 64'(last_ch), 2);
        chk("t6_after_crc", last_crc, crc_ref(f));

        // Random traffic with gaps and random back-pressure
        gap_en    = 1'b1;
        sink_mode = 0;
        for (int it = 0; it < 60; it++) begin
            n = $urandom_range(0, NCH - 1);
            if (!active[n]) load(n, rand_frame($urandom_range(1, 12)));
            repeat ($urandom_range(0, 6)) tick();
        end
        wait_idle(5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
